vdu_writer: RTL and testbench

VDU_WRITER -- requirements
Module: vdu_writer

---
 rtl/vdu_writer_pkg.sv | 48 ++++
 rtl/vdu_cursor.sv | 61 ++++++
 rtl/vdu_writer.sv | 167 ++++++++++++++++
 tb/tb_vdu_writer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdu_writer_pkg.sv
// Shared definitions for the VDU text writer: geometry defaults, control codes,
// FSM and cursor-operation encodings, and the linear address helper.
package vdu_writer_pkg;

  localparam int unsigned COLS_DEF  = 80;
  localparam int unsigned ROWS_DEF  = 25;
  localparam logic [7:0]  BLANK_DEF = 8'h20;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ROW_W  = 5;

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  typedef enum logic [2:0] {
    StIdle,
    StPut,
    StScrollRd,
    StScrollWr,
    StClear
  } state_e;

  typedef enum logic [2:0] {
    CurNone,
    CurAdvance,
    CurCr,
    CurLf,
    CurBs,
    CurHome
  } cursor_op_e;

  // row*cols + col as a sum of shifted rows; with a constant cols this folds to
  // a few adders (80 -> row<<6 + row<<4).
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0]  row,
                                                 input logic [COL_W-1:0]  col,
                                                 input logic [ADDR_W-1:0] cols);
    logic [ADDR_W-1:0] acc;
    acc = ADDR_W'(col);
    for (int b = 0; b < ADDR_W; b++) begin
      if (cols[b]) acc = acc + (ADDR_W'(row) << b);
    end
    return acc;
  endfunction

endpackage

// File: rtl/vdu_cursor.sv
// Text cursor: column/row counters with advance, wrap, CR, LF, BS and home.
// scroll_req flags that the requested operation runs off the bottom of the screen.
module vdu_cursor
  import vdu_writer_pkg::*;
#(
  parameter int unsigned COLS = COLS_DEF,
  parameter int unsigned ROWS = ROWS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  cursor_op_e       op,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             scroll_req
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  // Scroll is needed when a wrap or line feed would leave the last row.
  always_comb begin
    scroll_req = 1'b0;
    case (op)
      CurAdvance: scroll_req = (col == LAST_COL) && (row == LAST_ROW);
      CurLf:      scroll_req = (row == LAST_ROW);
      default:    scroll_req = 1'b0;
    endcase
  end

  // Counter update; on the last row the row holds and the writer scrolls instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      case (op)
        CurAdvance: begin
          if (col == LAST_COL) begin
            col <= '0;
            if (row != LAST_ROW) row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        CurCr: col <= '0;
        CurLf: begin
          if (row != LAST_ROW) row <= row + 1'b1;
        end
        CurBs: begin
          if (col != '0) col <= col - 1'b1;
        end
        CurHome: begin
          col <= '0;
          row <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vdu_writer.sv
// VDU text writer: takes character/control codes from the CPU port and turns
// them into video RAM writes, including scroll-up and full-screen clear.
module vdu_writer
  import vdu_writer_pkg::*;
#(
  parameter int unsigned COLS  = COLS_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter logic [7:0]  BLANK = BLANK_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] SCROLL_LAST   = ADDR_W'(COLS * (ROWS - 1) - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(COLS * (ROWS - 1));
  localparam logic [ADDR_W-1:0] SCREEN_LAST   = ADDR_W'(COLS * ROWS - 1);

  state_e            state;
  logic [ADDR_W-1:0] idx;
  logic [7:0]        wdata_q;
  logic              scroll_pend;
  logic              accept;
  logic              printable;
  logic              scroll_req;
  cursor_op_e        cur_op;

  vdu_cursor #(
    .COLS(COLS),
    .ROWS(ROWS)
  ) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .op        (cur_op),
    .col       (cursor_col),
    .row       (cursor_row),
    .scroll_req(scroll_req)
  );

  // Decode an accepted code into a cursor operation.
  always_comb begin
    accept    = din_valid && (state == StIdle);
    printable = (din >= 8'h20) && (din <= 8'h7E);
    cur_op    = CurNone;
    if (accept) begin
      if (printable) begin
        cur_op = CurAdvance;
      end else begin
        case (din)
          CODE_CR: cur_op = CurCr;
          CODE_LF: cur_op = CurLf;
          CODE_BS: cur_op = CurBs;
          CODE_FF: cur_op = CurHome;
          default: cur_op = CurNone;
        endcase
      end
    end
  end

  // Main FSM; each transition loads the memory strobes for the state it enters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StClear;
      idx         <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_addr    <= '0;
      wdata_q     <= '0;
      scroll_pend <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (accept) begin
            if (printable) begin
              state       <= StPut;
              mem_we      <= 1'b1;
              mem_addr    <= lin_addr(cursor_row, cursor_col, COLS_A);
              wdata_q     <= din;
              scroll_pend <= scroll_req;
            end else if (scroll_req) begin
              // Line feed on the last row.
              state    <= StScrollRd;
              mem_re   <= 1'b1;
              mem_addr <= COLS_A;
              idx      <= '0;
            end else if (din == CODE_FF) begin
              state    <= StClear;
              mem_we   <= 1'b1;
              mem_addr <= '0;
              wdata_q  <= BLANK;
              idx      <= '0;
            end
          end
        end
        StPut: begin
          mem_we <= 1'b0;
          if (scroll_pend) begin
            state    <= StScrollRd;
            mem_re   <= 1'b1;
            mem_addr <= COLS_A;
            idx      <= '0;
          end else begin
            state <= StIdle;
          end
        end
        StScrollRd: begin
          state    <= StScrollWr;
          mem_re   <= 1'b0;
          mem_we   <= 1'b1;
          mem_addr <= idx;
        end
        StScrollWr: begin
          if (idx == SCROLL_LAST) begin
            state    <= StClear;
            wdata_q  <= BLANK;
            mem_addr <= LAST_ROW_BASE;
            idx      <= LAST_ROW_BASE;
          end else begin
            state    <= StScrollRd;
            mem_we   <= 1'b0;
            mem_re   <= 1'b1;
            mem_addr <= idx + COLS_A + 11'd1;
            idx      <= idx + 11'd1;
          end
        end
        StClear: begin
          if (!mem_we) begin
            // First cycle after reset: strobes were forced off, so issue idx itself.
            mem_we   <= 1'b1;
            mem_addr <= idx;
            wdata_q  <= BLANK;
          end else if (idx == SCREEN_LAST) begin
            state  <= StIdle;
            mem_we <= 1'b0;
          end else begin
            mem_addr <= idx + 11'd1;
            idx      <= idx + 11'd1;
          end
        end
        default: begin
          state  <= StIdle;
          mem_we <= 1'b0;
          mem_re <= 1'b0;
        end
      endcase
    end
  end

  // Scroll writes forward the read data, which arrives the cycle after mem_re.
  always_comb begin
    mem_wdata = (state == StScrollWr) ? mem_rdata : wdata_q;
    din_ready = (state == StIdle);
    busy      = (state != StIdle);
  end

endmodule

// File: tb/tb_vdu_writer.sv
// Self-checking bench for vdu_writer: a screen model pushes expected RAM writes
// into a queue; a negedge monitor pops and compares every DUT write.
module tb_vdu_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 25;
  localparam int NCELL = COLS * ROWS;

  typedef struct packed {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_ready;
  logic [10:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  always #5 clk = ~clk;

  vdu_writer dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  // Video RAM model: synchronous write, read data valid the cycle after mem_re.
  logic [7:0] ram [2048];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  wr_t        exp_q[$];
  logic [7:0] scr [NCELL];
  int         mc = 0;
  int         mr = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_wr = 0;
  bit         sb_en = 1'b1;
  logic [10:0] last_wa;
  logic [7:0]  last_wd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: strobe rules every cycle, and every write against the scoreboard.
  always @(negedge clk) begin
    check("we_re_excl", 32'(mem_we & mem_re), 0);
    check("idle_quiet", 32'(!busy & (mem_we | mem_re)), 0);
    if (mem_we && sb_en) begin
      n_wr++;
      last_wa = mem_addr;
      last_wd = mem_wdata;
      if (exp_q.size() == 0) begin
        check("wr_unexpected", 32'(mem_we), 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic push(input int a, input logic [7:0] d);
    wr_t e;
    e.addr = 11'(a);
    e.data = d;
    exp_q.push_back(e);
    scr[a] = d;
  endtask

  task automatic push_clear(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) push(a, 8'h20);
  endtask

  task automatic push_scroll();
    for (int i = 0; i < COLS * (ROWS - 1); i++) push(i, scr[i + COLS]);
    push_clear(COLS * (ROWS - 1), NCELL - 1);
  endtask

  // Present one code (called at a negedge); returns at the negedge after acceptance.
  task automatic send(input logic [7:0] c);
    int n = 0;
    din       = c;
    din_valid = 1'b1;
    while (!din_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!din_ready) check("accept_timeout", 32'(din_ready), 1);
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Update the screen/cursor model, queue expected writes, then drive the code.
  task automatic tx(input logic [7:0] c);
    bit scroll = 1'b0;
    if (c >= 8'h20 && c <= 8'h7E) begin
      push(mr * COLS + mc, c);
      if (mc == COLS - 1) begin
        mc = 0;
        if (mr == ROWS - 1) scroll = 1'b1;
        else mr++;
      end else begin
        mc++;
      end
    end else if (c == 8'h0D) begin
      mc = 0;
    end else if (c == 8'h0A) begin
      if (mr == ROWS - 1) scroll = 1'b1;
      else mr++;
    end else if (c == 8'h08) begin
      if (mc > 0) mc--;
    end else if (c == 8'h0C) begin
      push_clear(0, NCELL - 1);
      mc = 0;
      mr = 0;
    end
    if (scroll) push_scroll();
    send(c);
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 20000) begin
      cyc++;
      @(negedge clk);
    end
    if (busy) check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic check_cur(input int c, input int r);
    check("cursor_col", 32'(cursor_col), 32'(c));
    check("cursor_row", 32'(cursor_row), 32'(r));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t, required < 5 ms", $time);
    $fatal(1);
  end

  initial begin
    int cyc;
    int bad;
    int n0;
    int n;
    reset     = 1'b1;
    din       = 8'h00;
    din_valid = 1'b0;
    for (int a = 0; a < NCELL; a++) scr[a] = 8'h00;

    // Reset state and the power-on clear.
    @(negedge clk);
    check("rst_din_ready", 32'(din_ready), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_re", 32'(mem_re), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    check("rst_busy", 32'(busy), 1);
    check_cur(0, 0);
    push_clear(0, NCELL - 1);
    reset = 1'b0;
    wait_idle(cyc);
    check("rst_clear_writes", 32'(n_wr), 2000);
    check("rst_sb_empty", 32'(exp_q.size()), 0);
    check("rst_ready", 32'(din_ready), 1);
    check_cur(0, 0);

    // 'A','B' at cursor 3,2.
    tx(8'h0A);
    tx(8'h0A);
    tx(8'h61);
    tx(8'h62);
    tx(8'h63);
    wait_idle(cyc);
    check_cur(3, 2);
    tx(8'h41);
    tx(8'h42);
    wait_idle(cyc);
    check("ab_last_addr", 32'(last_wa), 164);
    check("ab_last_data", 32'(last_wd), 8'h42);
    check("ab_ram163", 32'(ram[163]), 8'h41);
    check("ab_col", 32'(cursor_col), 5);

    // 79 printables, then CR, BS, LF; plus BS mid-row and ignored codes.
    tx(8'h0C);
    wait_idle(cyc);
    check_cur(0, 0);
    for (int i = 0; i < 79; i++) tx(8'(8'h30 + i % 64));
    wait_idle(cyc);
    check_cur(79, 0);
    tx(8'h0D);
    check_cur(0, 0);
    tx(8'h08);
    check_cur(0, 0);
    tx(8'h0A);
    check_cur(0, 1);
    tx(8'h71);
    tx(8'h72);
    wait_idle(cyc);
    tx(8'h08);
    check_cur(1, 1);
    n0 = n_wr;
    tx(8'h01);
    tx(8'h7F);
    tx(8'hC5);
    check_cur(1, 1);
    check("ignored_no_write", 32'(n_wr - n0), 0);

    // LF on the last row scrolls: row 1 of 'X' moves to row 0, last row blanked.
    tx(8'h0C);
    wait_idle(cyc);
    tx(8'h0A);
    for (int i = 0; i < 80; i++) tx(8'h58);
    for (int i = 0; i < 22; i++) tx(8'h0A);
    for (int i = 0; i < 10; i++) tx(8'h2E);
    wait_idle(cyc);
    check_cur(10, 24);
    n0 = n_wr;
    tx(8'h0A);
    wait_idle(cyc);
    check("scroll_busy_cycles", 32'(cyc), 3920);
    check("scroll_writes", 32'(n_wr - n0), 2000);
    bad = 0;
    for (int a = 0; a < 80; a++) if (ram[a] !== 8'h58) bad++;
    check("scroll_row0_x", 32'(bad), 0);
    bad = 0;
    for (int a = 1920; a < 2000; a++) if (ram[a] !== 8'h20) bad++;
    check("scroll_last_blank", 32'(bad), 0);
    check_cur(10, 24);

    // 'Z' at the bottom-right corner writes, then scrolls.
    for (int i = 0; i < 69; i++) tx(8'h2D);
    wait_idle(cyc);
    check_cur(79, 24);
    tx(8'h5A);
    check("z_we", 32'(mem_we), 1);
    check("z_addr", 32'(mem_addr), 1999);
    check("z_data", 32'(mem_wdata), 8'h5A);
    wait_idle(cyc);
    check_cur(0, 24);
    check("z_ram1919", 32'(ram[1919]), 8'h5A);
    check("z_ram1999", 32'(ram[1999]), 8'h20);

    // Reset 500 cycles into a scroll; a held code waits for the restarted clear.
    sb_en = 1'b0;
    send(8'h0A);
    repeat (500) @(negedge clk);
    n = 0;
    while (!mem_we && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("mid_busy", 32'(busy), 1);
    check("mid_we", 32'(mem_we), 1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_we", 32'(mem_we), 0);
    check("abort_re", 32'(mem_re), 0);
    check("abort_addr", 32'(mem_addr), 0);
    check("abort_ready", 32'(din_ready), 0);
    din       = 8'h41;
    din_valid = 1'b1;
    exp_q.delete();
    push_clear(0, NCELL - 1);
    push(0, 8'h41);
    mc    = 1;
    mr    = 0;
    sb_en = 1'b1;
    n0    = n_wr;
    @(negedge clk);
    check("abort_held_ready", 32'(din_ready), 0);
    reset = 1'b0;
    n = 0;
    while (!din_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("held_after_clear", 32'(n_wr - n0), 2000);
    @(posedge clk);
    @(negedge clk);
    din_valid = 1'b0;
    check("held_we", 32'(mem_we), 1);
    check("held_addr", 32'(mem_addr), 0);
    check("held_data", 32'(mem_wdata), 8'h41);
    wait_idle(cyc);
    check_cur(1, 0);
    check("final_sb_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
